alu_share_arbiter: RTL and testbench

Shares the single 32-bit datapath ALU between two requesters, e.g. the EX stage and a branch/address unit. Each requester uses a valid/ready handshake on both the request and response sides. Arbitration is round-robin, or fixed priority when configured. The block captures operands, drives the external combinational ALU for one cycle, registers the result, and holds the response until it is consumed.

---
 rtl/alu_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational 32-bit ALU between two valid/ready requesters.
// One operation is in flight at a time: capture operands, drive the ALU for a cycle, hold the result.
module alu_share_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp0_result,
    output logic [31:0]      rsp1_result,
    output logic             rsp0_zero,
    output logic             rsp1_zero,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
);

    // Encoding of the ALU add operation; the ALU is left idle on it between operations.
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_last_grant;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [3:0]       r_op;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [31:0]      r_rsp0_result;
    logic [31:0]      r_rsp1_result;
    logic             r_rsp0_zero;
    logic             r_rsp1_zero;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_sel;
    logic w_idle;
    logic w_accept;
    logic w_rsp_take;

    // Round-robin favours the port that did not win last; no lock-in, re-evaluated every IDLE cycle.
    always_comb begin
        w_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            w_sel = RR_EN ? ~r_last_grant : 1'b0;
        end else if (req1_valid) begin
            w_sel = 1'b1;
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign req0_ready = w_idle & req0_valid & ~w_sel;
    assign req1_ready = w_idle & req1_valid &  w_sel;
    assign w_accept   = req0_ready | req1_ready;
    assign w_rsp_take = (r_state == S_RESP) & (r_owner ? rsp1_ready : rsp0_ready);

    // NOTE: non-blocking assignments for every register so all state updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = ALU_ADD;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC: begin
                alu_a       = r_a;
                alu_b       = r_b;
                alu_op      = r_op;
                w_state_nxt = S_RESP;
            end
            S_RESP: if (w_rsp_take) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= ALU_ADD;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_cnt0        <= '0;
            r_cnt1        <= '0;
        end else begin
            if (w_accept) begin
                r_a          <= w_sel ? req1_a  : req0_a;
                r_b          <= w_sel ? req1_b  : req0_b;
                r_op         <= w_sel ? req1_op : req0_op;
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
                if (!w_sel && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
                if ( w_sel && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
            end

            if (r_state == S_EXEC) begin
                if (r_owner) begin
                    r_rsp1_result <= alu_result;
                    r_rsp1_zero   <= alu_zero;
                    r_rsp1_valid  <= 1'b1;
                end else begin
                    r_rsp0_result <= alu_result;
                    r_rsp0_zero   <= alu_zero;
                    r_rsp0_valid  <= 1'b1;
                end
            end

            if (w_rsp_take) begin
                if (r_owner) r_rsp1_valid <= 1'b0;
                else         r_rsp0_valid <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_zero   = r_rsp0_zero;
    assign rsp1_zero   = r_rsp1_zero;
    assign grant0_cnt  = r_cnt0;
    assign grant1_cnt  = r_cnt1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: round-robin (u_rr), fixed-priority (u_fp) and 2-bit-counter (u_sat) instances.
// Instance 0 responses are checked by a scoreboard against a behavioural ALU model.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq_v  [3][2];
    logic        rq_r  [3][2];
    logic [31:0] rq_a  [3][2];
    logic [31:0] rq_b  [3][2];
    logic [3:0]  rq_op [3][2];
    logic        rs_v  [3][2];
    logic        rs_r  [3][2];
    logic [31:0] rs_res[3][2];
    logic        rs_z  [3][2];
    logic [31:0] x_a   [3];
    logic [31:0] x_b   [3];
    logic [3:0]  x_op  [3];
    logic [31:0] x_res [3];
    logic        x_z   [3];
    logic [15:0] c0    [2];
    logic [15:0] c1    [2];
    logic [1:0]  s0;
    logic [1:0]  s1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rsp0_seen = 0;
    int   rsp1_seen = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural combinational ALU behind each instance.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            x_res[i] = alu_f(x_a[i], x_b[i], x_op[i]);
            x_z[i]   = (x_res[i] == 32'd0);
        end
    end

    alu_share_arbiter #(.RR_EN(1'b1), .CNT_W(16)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rq_v[0][0]), .req1_valid(rq_v[0][1]),
        .req0_ready(rq_r[0][0]), .req1_ready(rq_r[0][1]),
        .req0_a(rq_a[0][0]), .req1_a(rq_a[0][1]),
        .req0_b(rq_b[0][0]), .req1_b(rq_b[0][1]),
        .req0_op(rq_op[0][0]), .req1_op(rq_op[0][1]),
        .rsp0_valid(rs_v[0][0]), .rsp1_valid(rs_v[0][1]),
        .rsp0_ready(rs_r[0][0]), .rsp1_ready(rs_r[0][1]),
        .rsp0_result(rs_res[0][0]), .rsp1_result(rs_res[0][1]),
        .rsp0_zero(rs_z[0][0]), .rsp1_zero(rs_z[0][1]),
        .alu_a(x_a[0]), .alu_b(x_b[0]), .alu_op(x_op[0]),
        .alu_result(x_res[0]), .alu_zero(x_z[0]),
        .grant0_cnt(c0[0]), .grant1_cnt(c1[0])
    );

    alu_share_arbiter #(.RR_EN(1'b0), .CNT_W(16)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rq_v[1][0]), .req1_valid(rq_v[1][1]),
        .req0_ready(rq_r[1][0]), .req1_ready(rq_r[1][1]),
        .req0_a(rq_a[1][0]), .req1_a(rq_a[1][1]),
        .req0_b(rq_b[1][0]), .req1_b(rq_b[1][1]),
        .req0_op(rq_op[1][0]), .req1_op(rq_op[1][1]),
        .rsp0_valid(rs_v[1][0]), .rsp1_valid(rs_v[1][1]),
        .rsp0_ready(rs_r[1][0]), .rsp1_ready(rs_r[1][1]),
        .rsp0_result(rs_res[1][0]), .rsp1_result(rs_res[1][1]),
        .rsp0_zero(rs_z[1][0]), .rsp1_zero(rs_z[1][1]),
        .alu_a(x_a[1]), .alu_b(x_b[1]), .alu_op(x_op[1]),
        .alu_result(x_res[1]), .alu_zero(x_z[1]),
        .grant0_cnt(c0[1]), .grant1_cnt(c1[1])
    );

    alu_share_arbiter #(.RR_EN(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rq_v[2][0]), .req1_valid(rq_v[2][1]),
        .req0_ready(rq_r[2][0]), .req1_ready(rq_r[2][1]),
        .req0_a(rq_a[2][0]), .req1_a(rq_a[2][1]),
        .req0_b(rq_b[2][0]), .req1_b(rq_b[2][1]),
        .req0_op(rq_op[2][0]), .req1_op(rq_op[2][1]),
        .rsp0_valid(rs_v[2][0]), .rsp1_valid(rs_v[2][1]),
        .rsp0_ready(rs_r[2][0]), .rsp1_ready(rs_r[2][1]),
        .rsp0_result(rs_res[2][0]), .rsp1_result(rs_res[2][1]),
        .rsp0_zero(rs_z[2][0]), .rsp1_zero(rs_z[2][1]),
        .alu_a(x_a[2]), .alu_b(x_b[2]), .alu_op(x_op[2]),
        .alu_result(x_res[2]), .alu_zero(x_z[2]),
        .grant0_cnt(s0), .grant1_cnt(s1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for instance 0: pops one expectation per response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rs_v[0][0]) rsp0_seen++;
                if (rs_v[0][1]) rsp1_seen++;
                for (int p = 0; p < 2; p++) begin
                    if (rs_v[0][p] && rs_r[0][p]) begin
                        if (sb.size() == 0) begin
                            check("sb_unexpected_rsp", 32'(p), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            check("sb_port", 32'(p), 32'(e.port));
                            check("sb_result", rs_res[0][p], e.res);
                            check("sb_zero", 32'(rs_z[0][p]), 32'(e.zero));
                        end
                    end
                end
            end
        end
    end

    // Drive a request (caller is just after a rising edge) and hold it until the accept edge.
    task automatic issue(input int i, input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input bit push, input logic [31:0] er, input logic ez);
        bit ok = 1'b0;
        rq_a[i][p]  = a;
        rq_b[i][p]  = b;
        rq_op[i][p] = op;
        rq_v[i][p]  = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (rq_r[i][p]) begin
                ok = 1'b1;
                if (push) sb.push_back('{port: p[0], res: er, zero: ez});
            end
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rq_v[i][p] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Both ports valid continuously for four grants; checks grant order against exp_order.
    task automatic contend(input int i, input logic [3:0] exp_order);
        int    grants = 0;
        logic  g;
        logic [31:0] r;
        rq_a[i][0] = 32'd10; rq_b[i][0] = 32'd1; rq_op[i][0] = OP_ADD;
        rq_a[i][1] = 32'd20; rq_b[i][1] = 32'd3; rq_op[i][1] = OP_SUB;
        rq_v[i][0] = 1'b1;   rq_v[i][1] = 1'b1;
        for (int n = 0; n < 60 && grants < 4; n++) begin
            @(negedge clk);
            if (rq_r[i][0] || rq_r[i][1]) begin
                check("both_ready", 32'(rq_r[i][0] & rq_r[i][1]), 32'd0);
                g = rq_r[i][1];
                check($sformatf("grant_order_%0d_%0d", i, grants), 32'(g), 32'(exp_order[grants]));
                if (i == 0) begin
                    r = alu_f(rq_a[i][g], rq_b[i][g], rq_op[i][g]);
                    sb.push_back('{port: g, res: r, zero: (r == 32'd0)});
                end
                grants++;
                @(posedge clk); #1;
                rq_a[i][g] = rq_a[i][g] + 32'd3;
            end
        end
        check("contend_timeout", 32'(grants), 32'd4);
        rq_v[i][0] = 1'b0;
        rq_v[i][1] = 1'b0;
        if (i == 0) wait_drain();
        else repeat (4) begin @(posedge clk); #1; end
    endtask

    vec_t vecs[9];

    initial begin
        int   seen0;
        int   seen1;
        logic [31:0] last_res[2];
        logic [1:0]  exp_sat;

        vecs[0] = '{1'b1, 32'd9,         32'd9,         OP_SUB,  32'h0000_0000, 1'b1};
        vecs[1] = '{1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, OP_AND,  32'h00F0_000F, 1'b0};
        vecs[2] = '{1'b1, 32'h1234_0000, 32'h0000_5678, OP_OR,   32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_XOR,  32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'd1,         32'd31,        OP_SLL,  32'h8000_0000, 1'b0};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'd31,        OP_SRL,  32'h0000_0001, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         OP_SLT,  32'h0000_0001, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         OP_SLTU, 32'h0000_0000, 1'b1};
        vecs[8] = '{1'b1, 32'd3,         32'hFFFF_FFFF, OP_ADD,  32'h0000_0002, 1'b0};

        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                rq_v[i][p] = 1'b0; rq_a[i][p] = '0; rq_b[i][p] = '0; rq_op[i][p] = OP_ADD;
                rs_r[i][p] = 1'b1;
            end
        end

        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", 32'(rq_r[0][0]), 32'd0);
        check("rst_req1_ready", 32'(rq_r[0][1]), 32'd0);
        check("rst_rsp0_valid", 32'(rs_v[0][0]), 32'd0);
        check("rst_rsp1_valid", 32'(rs_v[0][1]), 32'd0);
        check("rst_rsp0_result", rs_res[0][0], 32'd0);
        check("rst_rsp1_zero", 32'(rs_z[0][1]), 32'd0);
        check("rst_alu_a", x_a[0], 32'd0);
        check("rst_alu_b", x_b[0], 32'd0);
        check("rst_alu_op", 32'(x_op[0]), 32'(OP_ADD));
        check("rst_grant0_cnt", 32'(c0[0]), 32'd0);
        check("rst_grant1_cnt", 32'(c1[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention straight after reset: round-robin then fixed priority.
        contend(0, 4'b1010);
        check("rr_grant0_cnt", 32'(c0[0]), 32'd2);
        check("rr_grant1_cnt", 32'(c1[0]), 32'd2);
        contend(1, 4'b0000);
        check("fp_grant0_cnt", 32'(c0[1]), 32'd4);
        check("fp_grant1_cnt", 32'(c1[1]), 32'd0);

        // Port 0 alone, 5 + 7: ready seen in cycle k, rsp_valid after edge k+2.
        reset_pulse();
        rq_a[0][0] = 32'd5; rq_b[0][0] = 32'd7; rq_op[0][0] = OP_ADD; rq_v[0][0] = 1'b1;
        @(negedge clk);
        check("p0_req0_ready", 32'(rq_r[0][0]), 32'd1);
        check("p0_req1_ready", 32'(rq_r[0][1]), 32'd0);
        sb.push_back('{port: 1'b0, res: 32'd12, zero: 1'b0});
        @(posedge clk); #1;
        rq_v[0][0] = 1'b0;
        @(negedge clk);
        check("p0_exec_valid", 32'(rs_v[0][0]), 32'd0);
        check("p0_exec_alu_a", x_a[0], 32'd5);
        check("p0_exec_alu_b", x_b[0], 32'd7);
        @(negedge clk);
        check("p0_rsp_valid", 32'(rs_v[0][0]), 32'd1);
        check("p0_rsp_result", rs_res[0][0], 32'd12);
        check("p0_rsp_zero", 32'(rs_z[0][0]), 32'd0);
        check("p0_resp_alu_quiet", x_a[0], 32'd0);
        check("p0_grant0_cnt", 32'(c0[0]), 32'd1);
        @(posedge clk); #1;
        wait_drain();
        last_res[0] = 32'd12;
        last_res[1] = 32'd0;

        // Table of single-port operations; the idle port's result must hold.
        foreach (vecs[v]) begin
            seen0 = rsp0_seen;
            seen1 = rsp1_seen;
            issue(0, int'(vecs[v].port), vecs[v].a, vecs[v].b, vecs[v].op, 1'b1, vecs[v].res, vecs[v].zero);
            wait_drain();
            check($sformatf("vec%0d_hold", v), rs_res[0][vecs[v].port], vecs[v].res);
            check($sformatf("vec%0d_other", v), rs_res[0][~vecs[v].port], last_res[~vecs[v].port]);
            if (vecs[v].port) check($sformatf("vec%0d_no_rsp0", v), 32'(rsp0_seen - seen0), 32'd0);
            else              check($sformatf("vec%0d_no_rsp1", v), 32'(rsp1_seen - seen1), 32'd0);
            last_res[vecs[v].port] = vecs[v].res;
        end

        // Backpressure on port 0 while port 1 waits.
        rs_r[0][0] = 1'b0;
        issue(0, 0, 32'h8000_0000, 32'd4, OP_SRA, 1'b1, 32'hF800_0000, 1'b0);
        rq_a[0][1] = 32'd1; rq_b[0][1] = 32'd2; rq_op[0][1] = OP_ADD; rq_v[0][1] = 1'b1;
        @(negedge clk);
        check("bp_exec_req1_ready", 32'(rq_r[0][1]), 32'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", n), 32'(rs_v[0][0]), 32'd1);
            check($sformatf("bp_result_%0d", n), rs_res[0][0], 32'hF800_0000);
            check($sformatf("bp_req1_ready_%0d", n), 32'(rq_r[0][1]), 32'd0);
        end
        @(posedge clk); #1;
        rs_r[0][0] = 1'b1;
        begin
            bit got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (rq_r[0][1]) begin
                    got = 1'b1;
                    check("bp_done_rsp0_valid", 32'(rs_v[0][0]), 32'd0);
                    sb.push_back('{port: 1'b1, res: 32'd3, zero: 1'b0});
                end
            end
            check("bp_req1_accept", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        rq_v[0][1] = 1'b0;
        wait_drain();

        // Reset while a port 1 operation is in EXEC.
        issue(0, 1, 32'd4, 32'd4, OP_XOR, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp1_valid", 32'(rs_v[0][1]), 32'd0);
        check("mid_rst_alu_a", x_a[0], 32'd0);
        check("mid_rst_alu_op", 32'(x_op[0]), 32'(OP_ADD));
        check("mid_rst_rsp1_result", rs_res[0][1], 32'd0);
        check("mid_rst_grant0_cnt", 32'(c0[0]), 32'd0);
        check("mid_rst_grant1_cnt", 32'(c1[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen1 = rsp1_seen;
        repeat (6) @(negedge clk);
        check("mid_rst_no_rsp1", 32'(rsp1_seen - seen1), 32'd0);
        @(posedge clk); #1;
        rq_a[0][0] = 32'd1; rq_b[0][0] = 32'd1; rq_op[0][0] = OP_ADD;
        rq_a[0][1] = 32'd2; rq_b[0][1] = 32'd2; rq_op[0][1] = OP_ADD;
        rq_v[0][0] = 1'b1;  rq_v[0][1] = 1'b1;
        @(negedge clk);
        check("post_rst_grant0", 32'(rq_r[0][0]), 32'd1);
        check("post_rst_grant1", 32'(rq_r[0][1]), 32'd0);
        sb.push_back('{port: 1'b0, res: 32'd2, zero: 1'b0});
        @(posedge clk); #1;
        rq_v[0][0] = 1'b0;
        rq_v[0][1] = 1'b0;
        wait_drain();

        // Saturation of a 2-bit grant counter.
        for (int k = 1; k <= 5; k++) begin
            issue(2, 0, 32'(k), 32'(k), OP_ADD, 1'b0, 32'd0, 1'b0);
            exp_sat = (k < 3) ? 2'(k) : 2'd3;
            check($sformatf("sat_cnt_%0d", k), 32'(s0), 32'(exp_sat));
            repeat (3) begin @(posedge clk); #1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
